fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the ram instruction port.
- Owns the PC and drives i_address; consumes i_read_data one cycle later.
- Delivers {pc, instruction} pairs to decode over a valid/ready handshake.
- Handles decode back-pressure via a 2-entry buffer and branch/jump redirects via squash.

Parameters:
DATA_WIDTH, 32, instruction width; matches ram DATA_WIDTH.
ADDR_WIDTH, 16, byte-address width; matches ram ADDR_WIDTH.
RESET_PC, 0, PC loaded on reset; word-aligned.

Ports:
clock  input  1  rising-edge clock shared with ram.
reset  input  1  asynchronous, active-low reset (0 = in reset).
i_address  output  ADDR_WIDTH  byte address to ram instruction port; always equals pc_q.
i_read_data  input  DATA_WIDTH  ram instruction word; valid on the edge after the address was presented.
redirect_valid  input  1  branch/jump taken; 1-cycle pulse from execute.
redirect_pc  input  ADDR_WIDTH  redirect target byte address.
out_valid  output  1  out_instr/out_pc hold a valid pair.
out_ready  input  1  decode accepts the pair this cycle.
out_instr  output  DATA_WIDTH  instruction word.
out_pc  output  ADDR_WIDTH  byte address of out_instr.

Behaviour:
- Reset (reset=0, async):
  - pc_q=RESET_PC; inflight_q=0; squash_q=0.
  - FIFO count=0; FIFO entries=0.
  - out_valid=0, out_instr=0, out_pc=0, i_address=RESET_PC.
  - Reset asserted mid-operation discards everything in flight and in the FIFO.
- ram read model: synchronous, 1 cycle. Address A presented in cycle N; i_read_data=mem[A] is sampled at the edge ending cycle N+1.
- pop = out_valid & out_ready.
- issue = !redirect_valid & ((count + inflight_q - pop) < 2).
- On issue:
  - inflight_q<=1; req_pc_q<=pc_q.
  - pc_q<=pc_q+4, wrapping modulo 2^ADDR_WIDTH (0xFFFC -> 0x0000).
- Otherwise inflight_q<=0.
- Response: when inflight_q=1 and squash_q=0, push {req_pc_q, i_read_data} at the edge ending that cycle. When squash_q=1, drop the response.
- FIFO: 2 entries, in-order.
  - out_* reflect the head entry.
  - Push and pop in the same cycle are legal; count unchanged.
  - Push when full cannot occur (guaranteed by the issue rule); assertion in bench.
- Redirect (redirect_valid=1, highest priority):
  - pc_q<=redirect_pc with bits[1:0] forced to 0.
  - FIFO count<=0.
  - squash_q<=inflight_q.
  - No issue that cycle.
  - out_valid forced 0 that cycle, so no pop occurs.
  - The first post-redirect instruction appears on out_valid 3 cycles after the redirect cycle (redirect edge, issue edge, push edge).
- Latency:
  - Reset release to first out_valid: 2 rising edges (issue edge, push edge).
  - Steady-state throughput with out_ready=1: one instruction per cycle.
- Back-pressure:
  - out_ready=0 holds out_valid/out_instr/out_pc stable.
  - Issue stops once count + inflight reaches 2.
  - pc_q is held and i_address is unchanged.
- Simultaneous redirect and out_ready=1: redirect wins; nothing is accepted.
- redirect_valid held for multiple cycles: each cycle reloads pc_q and flushes; the last target wins.

Decomposition:
- Shared package/header fetch_pkg:
  - INSTR_BYTES=4.
  - NOP_INSTR=32'h00000013.
  - FIFO_DEPTH=2.
- One sub-module, fetch_skid_fifo: 2-entry {pc, instr} FIFO.
  - Inputs: push, pop, flush.
  - Outputs: count, head.
  - flush has priority over push.
- The top level holds the PC, inflight/squash tracking and issue logic.

Test Plan:
1. Preload ram words at 0/4/8/12 = 0x11/0x22/0x33/0x44; release reset with out_ready=1 -> out_valid rises 2 edges later; pairs (0,0x11),(4,0x22),(8,0x33),(12,0x44) arrive on consecutive cycles.
2. Same preload; out_ready=0 from cycle 3 for 5 cycles -> out_pc/out_instr frozen at the head pair; i_address stops advancing; count=2 with no overflow; on release, stream resumes with no gap or duplicate.
3. Streaming from 0; redirect_valid pulse with redirect_pc=0x40 while a fetch is in flight (mem[0x40]=0xAA) -> in-flight and buffered instructions are never presented; next out_pc=0x40 with out_instr=0xAA, 3 cycles after the pulse.
4. redirect_pc=0x0043 -> i_address=0x0040 next cycle; out_pc=0x0040.
5. RESET_PC=0xFFF8 -> out_pc sequence 0xFFF8, 0xFFFC, 0x0000, 0x0004.
6. Assert reset for one cycle mid-stream with the FIFO full -> out_valid=0 and i_address=RESET_PC immediately (asynchronously); the stream restarts from RESET_PC 2 edges after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants for the instruction-fetch stage.
package fetch_pkg;
    localparam int INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int IDX_W = $clog2(FIFO_DEPTH);
endpackage

// File: rtl/fetch_skid_fifo.sv
// fetch_skid_fifo: small in-order {pc, instr} buffer; entry 0 is always the head.
module fetch_skid_fifo
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] push_pc,
    input  logic [DATA_WIDTH-1:0] push_instr,
    output logic [CNT_W-1:0]      count,
    output logic [ADDR_WIDTH-1:0] head_pc,
    output logic [DATA_WIDTH-1:0] head_instr
);
    logic [ADDR_WIDTH-1:0] pc_q    [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] instr_q [FIFO_DEPTH];
    logic [IDX_W-1:0]      widx;

    // a same-cycle pop shifts the queue down, so the write slot moves with it
    assign widx       = IDX_W'(count - CNT_W'(pop));
    assign head_pc    = pc_q[0];
    assign head_instr = instr_q[0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else if (flush) begin
            count <= '0;
        end else begin
            if (pop)
                for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                    pc_q[i]    <= pc_q[i+1];
                    instr_q[i] <= instr_q[i+1];
                end
            if (push) begin
                pc_q[widx]    <= push_pc;
                instr_q[widx] <= push_instr;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues one-cycle ram reads and hands {pc, instr}
// pairs to decode through a small skid buffer, squashing on redirects.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] i_address,
    input  logic [DATA_WIDTH-1:0] i_read_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc
);
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] req_pc_q;
    logic                  inflight_q;
    logic                  squash_q;
    logic [CNT_W-1:0]      count;
    logic [CNT_W:0]        occupancy;
    logic                  push;
    logic                  pop;
    logic                  issue;

    // occupancy counts buffered plus in-flight words so a response always has a slot
    assign occupancy = {1'b0, count} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    assign out_valid = (count != '0) && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign issue     = !redirect_valid && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
    assign push      = inflight_q && !squash_q;
    assign i_address = pc_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            squash_q   <= 1'b0;
        end else begin
            inflight_q <= issue;
            squash_q   <= redirect_valid && inflight_q;
            if (redirect_valid)
                pc_q <= redirect_pc & ~ADDR_WIDTH'(3);
            else if (issue) begin
                pc_q     <= pc_q + ADDR_WIDTH'(INSTR_BYTES);
                req_pc_q <= pc_q;
            end
        end
    end

    fetch_skid_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_pc   (req_pc_q),
        .push_instr(i_read_data),
        .count     (count),
        .head_pc   (out_pc),
        .head_instr(out_instr)
    );
endmodule
